// File: rtl/ps2_rx_fifo_pkg.sv
// Shared types and helpers for the PS/2 receive path: deframer states,
// frame length and the odd-parity check.
`timescale 1ns/1ps
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int PS2_FRAME_BITS = 11;

    // True when the 8 data bits plus the parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side handshake of the PS/2 scan-code buffer.
`timescale 1ns/1ps
interface ps2_rx_fifo_if;
    logic       rx_read;
    logic [7:0] rx_scan_code;
    logic       rx_data_ready;
    logic       rx_frame_err;
    logic       rx_overflow;

    modport master (
        input  rx_read,
        output rx_scan_code,
        output rx_data_ready,
        output rx_frame_err,
        output rx_overflow
    );

    modport slave (
        output rx_read,
        input  rx_scan_code,
        input  rx_data_ready,
        input  rx_frame_err,
        input  rx_overflow
    );
endinterface

// File: rtl/ps2_rx_fifo_buf.sv
// Synchronous circular FIFO with registered pop data; storage has no reset so
// it can map onto distributed or block RAM.
`timescale 1ns/1ps
module ps2_rx_fifo_buf #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] rd_data_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rd_data_reg <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop) begin
                rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = rd_data_reg;
    assign count   = count_reg;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin conditioning, 11-bit frame deframer with
// timeout, and a scan-code FIFO read through a pop-on-read handshake.
`timescale 1ns/1ps
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 1400,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_rx_fifo_if.master bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bit 0 carries ps2_clk, bit 1 carries ps2_data.
    logic [1:0]    meta_reg;
    logic [1:0]    sync_reg;
    logic          clk_s;
    logic          data_s;

    logic [FW-1:0] filt_cnt_reg;
    logic          filt_level_reg;
    logic          disagree;
    logic          flip;
    logic          fall;

    ps2_state_t    state_reg,  state_next;
    logic [7:0]    shift_reg,  shift_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic          parity_reg, parity_next;
    logic [TW-1:0] to_cnt_reg, to_cnt_next;
    logic          err_reg,    err_next;
    logic          push_reg,   push_next;
    logic          overflow_reg;

    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          pop_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_reg <= 2'b11;
            sync_reg <= 2'b11;
        end else begin
            meta_reg <= {ps2_data, ps2_clk};
            sync_reg <= meta_reg;
        end
    end

    assign clk_s  = sync_reg[0];
    assign data_s = sync_reg[1];

    // Level only changes after FILTER_LEN consecutive disagreeing samples.
    assign disagree = (clk_s != filt_level_reg);
    assign flip     = disagree && (filt_cnt_reg == FW'(FILTER_LEN - 1));
    assign fall     = flip && filt_level_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_cnt_reg   <= '0;
            filt_level_reg <= 1'b1;
        end else if (!disagree) begin
            filt_cnt_reg <= '0;
        end else if (flip) begin
            filt_cnt_reg   <= '0;
            filt_level_reg <= ~filt_level_reg;
        end else begin
            filt_cnt_reg <= filt_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            parity_reg  <= 1'b0;
            to_cnt_reg  <= '0;
            err_reg     <= 1'b0;
            push_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            parity_reg  <= parity_next;
            to_cnt_reg  <= to_cnt_next;
            err_reg     <= err_next;
            push_reg    <= push_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        parity_next  = parity_reg;
        to_cnt_next  = fall ? '0 : to_cnt_reg + 1'b1;
        err_next     = 1'b0;
        push_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                to_cnt_next = '0;
                if (fall) begin
                    if (!data_s) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fall) begin
                    shift_next   = {data_s, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == 3'd7)
                        state_next = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_next = data_s;
                    state_next  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    if (data_s && odd_parity_ok(shift_reg, parity_reg))
                        push_next = 1'b1;
                    else
                        err_next = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // A stalled partial frame is abandoned so the next start bit resyncs.
        if (state_reg != IDLE && !fall && to_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
            err_next    = 1'b1;
            state_next  = IDLE;
            to_cnt_next = '0;
        end
    end

    assign pop_ok = bus.rx_read && !fifo_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overflow_reg <= 1'b0;
        else if (push_reg && fifo_full && !pop_ok)
            overflow_reg <= 1'b1;
    end

    ps2_rx_fifo_buf #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_reg),
        .push_data (shift_reg),
        .pop       (pop_ok),
        .rd_data   (bus.rx_scan_code),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.rx_data_ready = (fifo_count != '0);
    assign bus.rx_frame_err  = err_reg;
    assign bus.rx_overflow   = overflow_reg;

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

PS/2 device-to-host receiver and scan-code buffer feeding the ZX keyboard matrix decoder. It samples the raw `ps2_clk`/`ps2_data` lines and deframes 11-bit PS/2 frames. Valid bytes are queued in a small FIFO and handed downstream through a pop-on-read handshake: `rx_data_ready`, `rx_read`, `rx_scan_code`. It sits between the board PS/2 pins and the keyboard decoder state machine.

## Interface
- `FILTER_LEN`, 8: consecutive identical synchronized samples needed to accept a new `ps2_clk` level.
- `TIMEOUT_CYC`, 1400: idle clock cycles (≈100 µs at 14 MHz) after which a partial frame is discarded.
- `FIFO_DEPTH`, 8: byte entries; power of two, ≥2.
- `clk`  in  1  system clock (14 MHz nominal).
- `reset_n`  in  1  reset, asynchronous, active-low.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `rx_read`  in  1  pop strobe from consumer, one `clk` cycle.
- `rx_scan_code`  out  8  last popped byte, registered.
- `rx_data_ready`  out  1  FIFO not empty.
- `rx_frame_err`  out  1  one-cycle pulse: bad start, parity or stop bit, or timeout.
- `rx_overflow`  out  1  sticky: a valid byte was dropped because the FIFO was full. Cleared only by reset.

## Operation
- Input conditioning:
  - Two-flop synchronizers on both pins.
  - The `ps2_clk` filter counts samples that disagree with the filtered level and flips the level after `FILTER_LEN` consecutive disagreeing samples.
  - A falling edge of the filtered clock is `fall`, a one-cycle pulse. Data is sampled from synchronized `ps2_data` on `fall`.
- Deframer FSM:
  - IDLE: on `fall` with data=0 go to DATA with bit count 0. On `fall` with data=1, raise `rx_frame_err` and stay in IDLE.
  - DATA: on each `fall`, shift data in LSB first. After the 8th bit go to PARITY.
  - PARITY: on `fall`, store the bit and go to STOP.
  - STOP: on `fall`, check that data=1 and that the XOR of the 8 data bits and the parity bit is 1 (odd parity).
    - Pass: push the byte and return to IDLE.
    - Fail: pulse `rx_frame_err`, discard the byte, return to IDLE.
  - Timeout: in any state except IDLE, a counter clears on every `fall` and otherwise increments. On reaching `TIMEOUT_CYC` it pulses `rx_frame_err`, discards the frame and returns to IDLE.
- FIFO:
  - Circular buffer with write pointer, read pointer and count, width log2(`FIFO_DEPTH`)+1.
  - A push when count==`FIFO_DEPTH` drops the byte and sets `rx_overflow`.
  - Pop happens on `rx_read` with count>0: `rx_scan_code <= mem[rd_ptr]` and the read pointer advances.
  - `rx_read` with count==0 is ignored and `rx_scan_code` holds.
  - Simultaneous push and pop: both occur, count is unchanged. A pop on a full FIFO with a simultaneous push does not overflow.
- No host-to-device (inhibit/transmit) support; the pins are input-only.

## Timing
- Reset values:
  - `rx_scan_code`=8'h00, `rx_data_ready`=0, `rx_frame_err`=0, `rx_overflow`=0.
  - FSM in IDLE, FIFO empty.
  - Filtered clock level = 1.
  - Synchronizers preset to 1.
- Reset asserted mid-frame or mid-pop aborts immediately. No partial byte survives.
- Pin-to-`fall` latency: 2 synchronizer cycles + `FILTER_LEN` cycles.
- Push timing: the byte is written on the cycle after the stop-bit `fall`. `rx_data_ready` rises the following cycle, because it is derived from the registered count.
- Read handshake:
  - The consumer asserts `rx_read` in cycle N.
  - `rx_scan_code` is valid from N+1 and holds until the next accepted pop.
  - `rx_data_ready` reflects the new count from N+1.
- Consumer contract: one pop per `rx_read` cycle. Back-to-back `rx_read` pulses pop consecutive entries.
- `rx_frame_err` is exactly one cycle per bad frame.

## Structure
- Package `ps2_pkg`:
  - FSM state enum {IDLE, DATA, PARITY, STOP}.
  - Constant `PS2_FRAME_BITS`=11.
  - Parity helper function.
- One sub-module, `ps2_rx_fifo_buf`: parameterized synchronous FIFO providing push, pop, full, empty, count and registered output. The deframer and input filter stay in the top.

## Test plan
- Clean frame for 8'h1C with correct odd parity (parity bit 0, since 0x1C has three ones), 12.5 kHz PS/2 clock → `rx_data_ready`=1. Then `rx_read` → `rx_scan_code`=8'h1C on the next cycle and `rx_data_ready`=0.
- Sequence F0, 1C → two pops in order return 8'hF0 then 8'h1C. Pop on empty → `rx_scan_code` stays 8'h1C.
- Frame 8'h29 with the parity bit flipped → one `rx_frame_err` pulse, no push. Frame with stop bit=0 → same result.
- 3-cycle glitches on `ps2_clk` during a frame for 8'h5A → filtered out, 8'h5A received correctly.
- Stop the clock after 4 data bits, wait `TIMEOUT_CYC`+2 cycles → `rx_frame_err` pulse. The following full frame 8'h12 is received correctly.
- Push 9 bytes without reading (`FIFO_DEPTH`=8) → `rx_overflow`=1 and the first 8 bytes pop in order. Assert `reset_n`=0 mid-frame → all outputs return to their reset values immediately.
